hazard_halt_unit: RTL and testbench
===================================

// Module: hazard_halt_unit
// PURPOSE
//  Pipeline control responder for the 5-stage RISC-V datapath. Consumes the datapath hazard taps
//  (register indices, PCSrcE, ResultSrcE0, RegWrite flags) and drives StallF/StallD/FlushD/FlushE/
//  ForwardAE/ForwardBE back into it. Adds a debug halt FSM that drains the pipeline on request,
//  plus saturating stall and flush counters.
// PARAMETERS
//  DRAIN_CYCLES  4   counted bubble cycles before HALTED (D->E->M->W->writeback)
//  CNT_W         32  width of the performance counters
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  Rs1D,Rs2D    in   5      source regs in Decode
//  Rs1E,Rs2E    in   5      source regs in Execute
//  RdE,RdM,RdW  in   5      destination regs in E/M/W
//  PCSrcE       in   1      taken branch/jump resolved in Execute
//  ResultSrcE0  in   1      1 = load in Execute
//  RegWriteM    in   1      M-stage instruction writes a register
//  RegWriteW    in   1      W-stage instruction writes a register
//  halt_req     in   1      debug halt request (level)
//  StallF       out  1      hold the PC register
//  StallD       out  1      hold the F/D register
//  FlushD       out  1      clear the F/D register
//  FlushE       out  1      clear the D/E register
//  ForwardAE    out  2      srcA select: 00 Rd1E, 01 ResultW, 10 ALUResultM
//  ForwardBE    out  2      srcB/store-data select, same encoding
//  halt_ack     out  1      registered; 1 while in HALTED
//  stall_cnt    out  CNT_W  cycles with StallD=1, saturating
//  flush_cnt    out  CNT_W  cycles with PCSrcE=1, saturating
// BEHAVIOUR
//  Clock and reset
//  - One clock domain. Reset is asynchronous, active-high.
//  - Reset state: RUN, drain counter 0, halt_ack 0, stall_cnt 0, flush_cnt 0.
//  Forwarding (combinational)
//  - ForwardAE = 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
//  - Otherwise 01 if RegWriteW & RdW!=0 & RdW==Rs1E. Otherwise 00.
//  - M beats W. ForwardBE is identical, using Rs2E.
//  - Forwarding is independent of FSM state.
//  Hazard terms (combinational)
//  - lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
//  FSM states: RUN, DRAIN, HALTED (encoded in hazard_pkg)
//  - RUN:
//    StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall | PCSrcE.
//    If halt_req=1, go to DRAIN with count=0.
//  - DRAIN, priority order:
//    (a) PCSrcE=1: StallF=0, StallD=0, FlushD=1, FlushE=1; count resets to 0.
//        The redirect must load the PC.
//    (b) else lwStall=1: StallF=1, StallD=1, FlushD=0, FlushE=1; count holds.
//    (c) else: StallF=1, StallD=0, FlushD=1, FlushE=0; count++.
//    When count reaches DRAIN_CYCLES-1 in case (c), go to HALTED.
//    halt_req dropping during DRAIN returns to RUN next cycle. The PC is intact because F was held.
//  - HALTED: StallF=1, StallD=0, FlushD=1, FlushE=1; halt_ack=1 from the first HALTED cycle.
//    When halt_req=0, go to RUN; halt_ack falls on the same edge.
//  Counters
//  - stall_cnt increments every cycle StallD=1.
//  - flush_cnt increments every cycle PCSrcE=1, in any state.
//  - Both saturate at all-ones and never wrap.
//  Reset mid-operation
//  - Reset during DRAIN or HALTED returns to RUN immediately and asynchronously.
//  - halt_ack goes to 0 without a clock edge.
// STRUCTURE
//  - hazard_pkg holds: state enum {RUN, DRAIN, HALTED}, forwarding encodings FWD_REG/FWD_W/FWD_M,
//    and the DRAIN_CYCLES default.
//  - One sub-module: hazard_fwd_sel (pure comparator, instantiated twice for A and B).
//  - FSM, drain counter and perf counters stay in the top module.
// TESTING
//  1. Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01.
//     Set Rs1E=0 -> 00.
//  2. ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0; stall_cnt +1 per cycle.
//  3. RUN, PCSrcE=1 for one cycle -> FlushD=FlushE=1, StallF=0, flush_cnt=1.
//  4. halt_req=1, no hazards -> DRAIN for 4 cycles, then halt_ack=1 on the 5th edge after the request.
//     Outputs StallF=1, FlushD=1.
//  5. PCSrcE=1 in DRAIN cycle 2 -> StallF=0 that cycle, count restarts.
//     halt_ack arrives 3 cycles later than in test 4.
//  6. rst=1 asynchronously while HALTED -> halt_ack=0, counters=0 before the next clk.
//     After release, halt_req=0 -> RUN behaviour.
//     Force stall_cnt to all-ones -> remains all-ones while StallD=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / debug-halt unit.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;

   localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding source select for one Execute-stage operand; the Memory stage wins over Writeback.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] rs_e_i,
   input  logic [4:0] rd_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       reg_write_m_i,
   input  logic       reg_write_w_i,
   output logic [1:0] fwd_o
);

   always_comb begin
      fwd_o = FWD_REG;
      if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
         fwd_o = FWD_M;
      end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
         fwd_o = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_halt_unit.sv
// Hazard responder for the 5-stage pipeline: forwarding, load-use stall, branch flush,
// a debug halt FSM that drains the pipeline, and saturating stall/flush counters.
//
// state  | meaning
// RUN    | normal hazard handling
// DRAIN  | fetch held, bubbles counted until the pipeline is empty
// HALTED | pipeline empty, halt_ack high until halt_req drops
module hazard_halt_unit
   import hazard_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             PCSrcE,
   input  logic             ResultSrcE0,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             halt_req,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             halt_ack,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

   hz_state_t        state_q;
   logic [DW-1:0]    drain_q;
   logic             halt_ack_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic             lw_stall;

   hazard_fwd_sel u_fwd_a (
      .rs_e_i        (Rs1E),
      .rd_m_i        (RdM),
      .rd_w_i        (RdW),
      .reg_write_m_i (RegWriteM),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (ForwardAE)
   );

   hazard_fwd_sel u_fwd_b (
      .rs_e_i        (Rs2E),
      .rd_m_i        (RdM),
      .rd_w_i        (RdW),
      .reg_write_m_i (RegWriteM),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (ForwardBE)
   );

   assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   always_comb begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
      case (state_q)
         DRAIN: begin
            // A redirect must still load the PC, so fetch is released for that cycle.
            if (PCSrcE) begin
               StallF = 1'b0; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b1;
            end else if (lw_stall) begin
               StallF = 1'b1; StallD = 1'b1; FlushD = 1'b0; FlushE = 1'b1;
            end else begin
               StallF = 1'b1; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b0;
            end
         end
         HALTED: begin
            StallF = 1'b1; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         drain_q    <= '0;
         halt_ack_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (halt_req) begin
                  state_q <= DRAIN;
                  drain_q <= '0;
               end
            end
            DRAIN: begin
               if (!halt_req) begin
                  state_q <= RUN;
               end else if (PCSrcE) begin
                  drain_q <= '0;
               end else if (!lw_stall) begin
                  if (drain_q == DRAIN_LAST) begin
                     state_q    <= HALTED;
                     halt_ack_q <= 1'b1;
                  end else begin
                     drain_q <= drain_q + DW'(1);
                  end
               end
            end
            HALTED: begin
               if (!halt_req) begin
                  state_q    <= RUN;
                  halt_ack_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= RUN;
               halt_ack_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (StallD && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (PCSrcE && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign halt_ack  = halt_ack_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_halt_unit.sv
// Self-checking bench for hazard_halt_unit: directed scenarios plus a randomized run
// compared every cycle against a behavioural model of the pipeline-control rules.
module tb_hazard_halt_unit;

   localparam int DC   = 4;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          PCSrcE, ResultSrcE0, RegWriteM, RegWriteW, halt_req;
   logic          StallF, StallD, FlushD, FlushE, halt_ack;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // model: drain progress, halted flag, counters as plain integers
   bit m_draining, m_halted;
   int m_bubbles, m_stall, m_flush;

   hazard_halt_unit #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .halt_req(halt_req),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .halt_ack(halt_ack),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int fwd_exp(input int rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2;
      if (RegWriteW && RdW != 0 && RdW == rs) return 1;
      return 0;
   endfunction

   function automatic bit lw_exp();
      return ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
   endfunction

   // Expected {StallF, StallD, FlushD, FlushE} for the current inputs.
   function automatic bit [3:0] ctl_exp();
      bit lw = lw_exp();
      if (m_halted)   return 4'b1011;
      if (m_draining) begin
         if (PCSrcE) return 4'b0011;
         if (lw)     return 4'b1101;
         return 4'b1010;
      end
      return {lw, lw, PCSrcE, lw | PCSrcE};
   endfunction

   task automatic model_reset();
      m_draining = 0; m_halted = 0; m_bubbles = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_clock();
      bit [3:0] c = ctl_exp();
      if (c[2] && m_stall < CMAX) m_stall++;
      if (PCSrcE && m_flush < CMAX) m_flush++;
      if (m_halted) begin
         if (!halt_req) m_halted = 0;
      end else if (m_draining) begin
         if (!halt_req)           m_draining = 0;
         else if (PCSrcE)         m_bubbles = 0;
         else if (!lw_exp()) begin
            m_bubbles++;
            if (m_bubbles == DC) begin m_draining = 0; m_halted = 1; end
         end
      end else if (halt_req) begin
         m_draining = 1; m_bubbles = 0;
      end
   endtask

   task automatic compare_all();
      bit [3:0] c = ctl_exp();
      chk("StallF", StallF, c[3]);
      chk("StallD", StallD, c[2]);
      chk("FlushD", FlushD, c[1]);
      chk("FlushE", FlushE, c[0]);
      chk("ForwardAE", ForwardAE, fwd_exp(Rs1E));
      chk("ForwardBE", ForwardBE, fwd_exp(Rs2E));
      chk("halt_ack", halt_ack, m_halted);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
   endtask

   // Inputs are set just after a falling edge; check, then advance model at the rising edge.
   task automatic do_cycle(input bit rand_rst);
      #2;
      compare_all();
      if (rand_rst) begin
         rst = 1'b1;
         #1;
         model_reset();
         chk("async_rst_ack", halt_ack, 0);
         chk("async_rst_stall", stall_cnt, 0);
         chk("async_rst_flush", flush_cnt, 0);
         rst = 1'b0;
      end
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      PCSrcE = 0; ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0;
   endtask

   initial begin
      int edges;
      rst = 1'b1;
      halt_req = 1'b0;
      clear_inputs();
      model_reset();
      #3;
      chk("reset_ack", halt_ack, 0);
      chk("reset_stall_cnt", stall_cnt, 0);
      chk("reset_flush_cnt", flush_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // forwarding priority
      Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
      #1 chk("t1_fwd_m", ForwardAE, 2);
      do_cycle(0);
      RegWriteM = 0;
      #1 chk("t1_fwd_w", ForwardAE, 1);
      do_cycle(0);
      Rs1E = 0;
      #1 chk("t1_fwd_x0", ForwardAE, 0);
      do_cycle(0);

      // load-use stall
      clear_inputs();
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
      #1 chk("t2_ctl", {StallF, StallD, FlushD, FlushE}, 4'b1101);
      repeat (3) do_cycle(0);
      chk("t2_stall_cnt", stall_cnt, 3);

      // branch flush in RUN
      clear_inputs();
      PCSrcE = 1;
      #1 chk("t3_ctl", {StallF, FlushD, FlushE}, 3'b011);
      do_cycle(0);
      PCSrcE = 0;
      #1 chk("t3_flush_cnt", flush_cnt, 1);

      // clean drain: ack on the 5th edge after request
      halt_req = 1;
      for (int i = 1; i <= 5; i++) begin
         do_cycle(0);
         chk("t4_ack_edge", halt_ack, (i == 5));
         if (i < 5) chk("t4_drain_ctl", {StallF, FlushD}, 2'b11);
      end
      halt_req = 0;
      do_cycle(0);
      chk("t4_ack_fall", halt_ack, 0);
      do_cycle(0);

      // redirect in the third drain cycle delays ack by 3 edges
      halt_req = 1;
      edges = 0;
      for (int i = 1; i <= 20 && !halt_ack; i++) begin
         PCSrcE = (i == 4);
         if (i == 4) #1 chk("t5_redirect_stallf", StallF, 0);
         do_cycle(0);
         edges = i;
      end
      PCSrcE = 0;
      chk("t5_ack_edges", edges, 8);
      chk("t5_ack", halt_ack, 1);

      // async reset while halted
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t6_ack_async", halt_ack, 0);
      chk("t6_stall_async", stall_cnt, 0);
      chk("t6_flush_async", flush_cnt, 0);
      halt_req = 0;
      #1 rst = 1'b0;
      @(negedge clk);
      PCSrcE = 1;
      #1 chk("t6_run_ctl", {StallF, FlushD, FlushE}, 3'b011);
      do_cycle(0);
      PCSrcE = 0;

      // stall counter saturation
      ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
      repeat (CMAX + 10) do_cycle(0);
      chk("t6_stall_sat", stall_cnt, CMAX);
      clear_inputs();

      // randomized run
      for (int i = 0; i < 4000; i++) begin
         Rs1D = 5'($urandom_range(0, 3));
         Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3));
         Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3));
         RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         RegWriteM   = 1'($urandom_range(0, 1));
         RegWriteW   = 1'($urandom_range(0, 1));
         PCSrcE      = ($urandom_range(0, 9) == 0);
         ResultSrcE0 = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
         do_cycle($urandom_range(0, 699) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
